// File: rtl/mem_fill_arbiter.sv
// mem_fill_arbiter: shares one pipelined main memory between I-cache and D-cache miss handlers
// Ports: clk, rst_n (async active-low);
//   I side: i_req, i_addr -> i_grant, i_fill_valid, i_fill_done
//   D side: d_req, d_wr, d_addr, d_wdata -> d_grant, d_fill_valid, d_fill_done, d_wr_done
//   return path: fill_data, fill_word; memory: mem_en, mem_wr, mem_addr, mem_wdata, mem_rdata, mem_rvalid
//   busy: high whenever a transfer owns memory (pipeline stall)
module mem_fill_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int BLOCK_WORDS = 8,
   parameter int STARVE_MAX  = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_req,
   input  logic [ADDR_W-1:0]              i_addr,
   output logic                           i_grant,
   output logic                           i_fill_valid,
   output logic                           i_fill_done,
   input  logic                           d_req,
   input  logic                           d_wr,
   input  logic [ADDR_W-1:0]              d_addr,
   input  logic [DATA_W-1:0]              d_wdata,
   output logic                           d_grant,
   output logic                           d_fill_valid,
   output logic                           d_fill_done,
   output logic                           d_wr_done,
   output logic [DATA_W-1:0]              fill_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
   output logic                           mem_en,
   output logic                           mem_wr,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   input  logic [DATA_W-1:0]              mem_rdata,
   input  logic                           mem_rvalid,
   output logic                           busy
);
   localparam int CW = $clog2(BLOCK_WORDS);
   localparam int SW = $clog2(STARVE_MAX + 1);
   typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;
   state_t            r_state, w_next;
   logic [ADDR_W-1:0] r_addr, w_base;
   logic [DATA_W-1:0] r_wdata;
   // extra MSB lets the issue counter park at BLOCK_WORDS while returns lag
   logic [CW:0]       r_iss;
   logic [CW-1:0]     r_ret;
   logic [SW-1:0]     r_starve;
   logic              w_fill, w_issue, w_ret, w_last, w_pick_d;
   assign w_fill   = (r_state == FILL_I) || (r_state == FILL_D);
   assign w_issue  = w_fill && !r_iss[CW];
   // a return only counts if a read is actually outstanding
   assign w_ret    = w_fill && mem_rvalid && ({1'b0, r_ret} < r_iss);
   assign w_last   = w_ret && (r_ret == CW'(BLOCK_WORDS - 1));
   assign w_pick_d = d_req && !(i_req && r_starve == SW'(STARVE_MAX));
   assign w_base   = r_addr & ~ADDR_W'(2 * BLOCK_WORDS - 1);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_iss    <= '0;
         r_ret    <= '0;
         r_starve <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE) begin
            r_addr   <= w_pick_d ? d_addr : i_addr;
            r_wdata  <= d_wdata;
            r_iss    <= '0;
            r_ret    <= '0;
            r_starve <= (w_pick_d && i_req) ? r_starve + 1'b1 : '0;
         end else begin
            if (w_issue) r_iss <= r_iss + 1'b1;
            if (w_ret) r_ret <= r_ret + 1'b1;
         end
      end
   end
   always_comb begin
      w_next = (r_state == IDLE) ? (w_pick_d ? (d_wr ? WRITE : FILL_D) : (i_req ? FILL_I : IDLE))
             : (w_fill && !w_last) ? r_state : IDLE;
   end
   always_comb begin
      i_grant      = r_state == FILL_I;
      d_grant      = (r_state == FILL_D) || (r_state == WRITE);
      i_fill_valid = w_ret && (r_state == FILL_I);
      d_fill_valid = w_ret && (r_state == FILL_D);
      i_fill_done  = w_last && (r_state == FILL_I);
      d_fill_done  = w_last && (r_state == FILL_D);
      d_wr_done    = r_state == WRITE;
      fill_data    = w_ret ? mem_rdata : '0;
      fill_word    = w_ret ? r_ret : '0;
      mem_en       = w_issue || (r_state == WRITE);
      mem_wr       = r_state == WRITE;
      mem_addr     = (r_state == WRITE) ? r_addr : w_issue ? w_base + ADDR_W'({r_iss[CW-1:0], 1'b0}) : '0;
      mem_wdata    = (r_state == WRITE) ? r_wdata : '0;
      busy         = r_state != IDLE;
   end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// tb_mem_fill_arbiter: self-checking bench for mem_fill_arbiter (vector table, directed corners, random traffic vs. reference model)
module tb_mem_fill_arbiter;
   localparam int BW = 8, MEM_LAT = 4, SMAX = 2;
   logic        clk = 0, rst_n = 1;
   logic        i_req = 0, d_req = 0, d_wr = 0, mem_rvalid = 0;
   logic [15:0] i_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
   logic        i_grant, i_fill_valid, i_fill_done, d_grant, d_fill_valid, d_fill_done, d_wr_done;
   logic        mem_en, mem_wr, busy;
   logic [15:0] fill_data, mem_addr, mem_wdata;
   logic [2:0]  fill_word;
   logic [60:0] outs;
   mem_fill_arbiter dut (
      .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant),
      .i_fill_valid(i_fill_valid), .i_fill_done(i_fill_done), .d_req(d_req), .d_wr(d_wr),
      .d_addr(d_addr), .d_wdata(d_wdata), .d_grant(d_grant), .d_fill_valid(d_fill_valid),
      .d_fill_done(d_fill_done), .d_wr_done(d_wr_done), .fill_data(fill_data), .fill_word(fill_word),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .busy(busy)
   );
   assign outs = {busy, i_grant, i_fill_valid, i_fill_done, d_grant, d_fill_valid, d_fill_done, d_wr_done,
                  mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word};
   always #5 clk = ~clk;
   int n_chk = 0, n_fail = 0;
   function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endfunction
   function automatic logic [15:0] dfn(logic [15:0] a);
      return a ^ 16'hA5C3;
   endfunction
   // memory: in-order returns MEM_LAT cycles after issue; stall 1 = fixed gaps, 2 = random gaps
   logic [15:0] mq_d[$];
   int          mq_t[$];
   int          stall = 0, cyc = 0;
   always @(posedge clk) begin
      #1;
      mem_rvalid = 0;
      mem_rdata  = 16'($urandom);
      if (mq_t.size() > 0 && mq_t[0] <= cyc &&
          !((stall == 1 && cyc % 3 != 0) || (stall == 2 && $urandom_range(0, 2) == 0))) begin
         mem_rvalid = 1;
         mem_rdata  = mq_d.pop_front();
         void'(mq_t.pop_front());
      end
   end
   // requesters: hold until done, then drop (or, in d_cont mode, re-request at a new address)
   bit rnd_en = 0, d_cont = 0, seen_i_done = 0, seen_d_done = 0;
   always @(posedge clk) begin
      #1;
      if (seen_i_done) i_req = 0;
      else if (rnd_en && !i_req && $urandom_range(0, 3) == 0) begin
         i_req  = 1;
         i_addr = 16'($urandom);
      end
      if (seen_d_done) begin
         if (d_cont) d_addr = d_addr ^ 16'h0200;
         else d_req = 0;
      end else if (rnd_en && !d_req && $urandom_range(0, 3) == 0) begin
         d_req   = 1;
         d_wr    = 1'($urandom_range(0, 1));
         d_addr  = 16'($urandom);
         d_wdata = 16'($urandom);
      end
   end
   // reference model: transaction owner plus queues of addresses still to issue / awaiting return
   typedef struct packed {
      logic busy, ig, ifv, ifd, dg, dfv, dfd, dwd, en, wr;
      logic [15:0] addr, wdata, data;
      logic [2:0] word;
   } obs_t;
   obs_t        e;
   int          m_own = 0, m_starve = 0, m_got = 0;
   logic [15:0] m_waddr, m_wdata;
   logic [15:0] m_iq[$], m_rq[$];
   int          gq[$], gc[$];
   int          i_done_c = -100, d_done_c = -100;
   bit          prev_g = 0;
   task automatic load(input logic [15:0] a);
      m_got = 0;
      m_iq.delete();
      m_rq.delete();
      for (int k = 0; k < BW; k++) m_iq.push_back(16'(a - a % (2 * BW) + 2 * k));
   endtask
   always @(negedge clk) begin
      e = '0;
      if (!rst_n) begin
         m_own = 0;
         m_starve = 0;
         m_got = 0;
         m_iq.delete();
         m_rq.delete();
      end else if (m_own == 0) begin
         if (d_req && !(i_req && m_starve == SMAX)) begin
            m_starve = i_req ? m_starve + 1 : 0;
            if (d_wr) begin
               m_own = 3;
               m_waddr = d_addr;
               m_wdata = d_wdata;
            end else begin
               m_own = 2;
               load(d_addr);
            end
         end else if (i_req) begin
            m_own = 1;
            m_starve = 0;
            load(i_addr);
         end else m_starve = 0;
      end else if (m_own == 3) begin
         e.busy = 1; e.dg = 1; e.en = 1; e.wr = 1; e.dwd = 1;
         e.addr = m_waddr;
         e.wdata = m_wdata;
         m_own = 0;
      end else begin
         e.busy = 1;
         if (m_own == 1) e.ig = 1; else e.dg = 1;
         if (mem_rvalid && m_rq.size() > 0) begin
            e.data = dfn(m_rq.pop_front());
            e.word = 3'(m_got);
            if (m_own == 1) e.ifv = 1; else e.dfv = 1;
            if (m_got == BW - 1) begin
               if (m_own == 1) e.ifd = 1; else e.dfd = 1;
            end
            m_got++;
         end
         if (m_iq.size() > 0) begin
            e.en = 1;
            e.addr = m_iq[0];
            m_rq.push_back(m_iq.pop_front());
         end
         if (m_got == BW) m_own = 0;
      end
      check($sformatf("outputs@cycle%0d", cyc), 64'(outs), 64'(e));
      seen_i_done = i_fill_done;
      seen_d_done = d_fill_done | d_wr_done;
      if (i_fill_done) i_done_c = cyc;
      if (d_fill_done) d_done_c = cyc;
      if ((i_grant | d_grant) && !prev_g) begin
         gq.push_back(i_grant ? 1 : 2);
         gc.push_back(cyc);
      end
      prev_g = i_grant | d_grant;
      if (mem_en && !mem_wr) begin
         mq_d.push_back(dfn(mem_addr));
         mq_t.push_back(cyc + MEM_LAT);
      end
      cyc++;
   end
   function automatic int gside(int i);
      return (i < gq.size()) ? gq[i] : -1;
   endfunction
   function automatic int gcyc(int i);
      return (i < gc.size()) ? gc[i] : -1000;
   endfunction
   task automatic wait_idle();
      int k;
      for (k = 0; k < 300; k++) begin
         @(negedge clk); #1;
         if (!busy && !i_req && !d_req && mq_t.size() == 0) break;
      end
      check("idle_reached", 64'(k < 300), 1);
   endtask
   task automatic wait_grants(input int n);
      int k;
      for (k = 0; k < 200 && gq.size() < n; k++) begin
         @(negedge clk); #1;
      end
      check("grants_seen", 64'(gq.size() >= n), 1);
   endtask
   typedef struct {
      logic ir; logic [15:0] ia; logic dr, dw; logic [15:0] da, dd;
      int side; logic [15:0] a0; int done_off;
   } vec_t;
   vec_t        vt[5];
   int          n0, done_c, nv, nfv;
   logic [15:0] a0;
   int          wq[$];
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end
   initial begin
      vt[0] = '{1, 16'h1236, 0, 0, 16'h0000, 16'h0000, 1, 16'h1230, 12};
      vt[1] = '{0, 16'h0000, 1, 0, 16'h0047, 16'h0000, 2, 16'h0040, 12};
      vt[2] = '{0, 16'h0000, 1, 1, 16'h00A2, 16'hBEEF, 2, 16'h00A2, 1};
      vt[3] = '{1, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 1, 16'hFFF0, 12};
      vt[4] = '{0, 16'h0000, 1, 1, 16'h1235, 16'h1234, 2, 16'h1235, 1};
      #1 rst_n = 0;
      @(negedge clk); #1;
      check("reset_outputs", 64'(outs), 0);
      @(posedge clk); #1 rst_n = 1;
      for (int r = 0; r < 5; r++) begin
         wait_idle();
         gq.delete(); gc.delete();
         @(posedge clk); #1;
         n0 = cyc;
         i_req = vt[r].ir; i_addr = vt[r].ia;
         d_req = vt[r].dr; d_wr = vt[r].dw; d_addr = vt[r].da; d_wdata = vt[r].dd;
         done_c = -1; a0 = 0;
         for (int k = 0; k < 40 && done_c < 0; k++) begin
            @(negedge clk); #1;
            if (k == 1) a0 = mem_addr;
            if (i_fill_done | d_fill_done | d_wr_done) done_c = k;
         end
         check($sformatf("vec%0d_grant_side", r), gside(0), vt[r].side);
         check($sformatf("vec%0d_grant_offset", r), gcyc(0) - n0, 1);
         check($sformatf("vec%0d_first_addr", r), a0, vt[r].a0);
         check($sformatf("vec%0d_done_offset", r), done_c, vt[r].done_off);
      end
      wait_idle();
      gq.delete(); gc.delete();
      @(posedge clk); #1;
      n0 = cyc;
      i_req = 1; i_addr = 16'h2222; d_req = 1; d_wr = 0; d_addr = 16'h0040;
      wait_grants(2);
      check("both_first_side", gside(0), 2);
      check("both_second_side", gside(1), 1);
      check("both_d_done_offset", d_done_c - n0, 12);
      check("both_i_grant_after_d_done", gcyc(1) - d_done_c, 2);
      wait_idle();
      gq.delete(); gc.delete();
      @(posedge clk); #1;
      d_cont = 1;
      i_req = 1; i_addr = 16'h4000; d_req = 1; d_wr = 0; d_addr = 16'h0100;
      wait_grants(3);
      d_cont = 0;
      check("starve_grant0", gside(0), 2);
      check("starve_grant1", gside(1), 2);
      check("starve_grant2", gside(2), 1);
      wait_idle();
      stall = 1;
      wq.delete();
      @(posedge clk); #1;
      i_req = 1; i_addr = 16'h3456;
      done_c = -1; nv = 0;
      for (int k = 0; k < 200 && done_c < 0; k++) begin
         @(negedge clk); #1;
         if (i_fill_valid) wq.push_back(int'(fill_word));
         if (i_fill_done) begin
            done_c = k;
            nv = wq.size();
         end
      end
      check("stall_words_at_done", nv, 8);
      check("stall_done_late", 64'(done_c > 12), 1);
      for (int j = 0; j < 8; j++) check($sformatf("stall_word%0d", j), (j < wq.size()) ? wq[j] : -1, j);
      wait_idle();
      stall = 0;
      @(posedge clk); #1;
      i_req = 1; i_addr = 16'h5678;
      done_c = -1;
      for (int k = 0; k < 40 && done_c < 0; k++) begin
         @(negedge clk); #1;
         if (i_fill_valid && fill_word == 3'd2) done_c = k;
      end
      check("third_word_seen", 64'(done_c >= 0), 1);
      #1 rst_n = 0; i_req = 0;
      #1 check("async_reset_outputs", 64'(outs), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      nfv = 0;
      repeat (12) begin
         @(negedge clk); #1;
         if (i_fill_valid | d_fill_valid) nfv++;
      end
      check("late_rvalid_ignored", nfv, 0);
      wait_idle();
      stall = 2;
      rnd_en = 1;
      repeat (500) @(posedge clk);
      rnd_en = 0;
      wait_idle();
      stall = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
